// File: rtl/rr_packet_mux.sv
// Round-robin packet multiplexer: N valid/ready/last sources share one output stream.
// Grant is registered and held for a whole packet; switches with no bubble when another port waits.
module rr_packet_mux #(
  parameter int N  = 3,
  parameter int DW = 64,
  localparam int IW = $clog2(N)
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N-1:0]    in_valid,
  input  logic [N*DW-1:0] in_data,
  input  logic [N-1:0]    in_last,
  output logic [N-1:0]    in_ready,
  output logic            out_valid,
  output logic [DW-1:0]   out_data,
  output logic            out_last,
  output logic [IW-1:0]   out_id,
  input  logic            out_ready,
  output logic [N-1:0]    grant
);

  typedef enum logic {IDLE, BUSY} state_e;

  state_e        state_q, state_d;
  logic [N-1:0]  grant_q, grant_d;
  logic [IW-1:0] gid_q, gid_d;
  logic [IW-1:0] last_winner_q, last_winner_d;

  logic [IW-1:0] base;
  logic [IW-1:0] idx;
  logic [IW-1:0] sel;
  logic          found;
  int            span;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= IDLE;
      grant_q       <= '0;
      gid_q         <= '0;
      last_winner_q <= IW'(N - 1);
    end else begin
      state_q       <= state_d;
      grant_q       <= grant_d;
      gid_q         <= gid_d;
      last_winner_q <= last_winner_d;
    end
  end

  always_comb begin
    out_valid = 1'b0;
    out_data  = '0;
    out_last  = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (grant_q[i]) begin
        out_valid = in_valid[i];
        out_data  = in_data[i*DW +: DW];
        out_last  = in_last[i];
      end
    end
    in_ready = grant_q & {N{out_ready}};
    out_id   = gid_q;
    grant    = grant_q;
  end

  // When busy the search starts after the current owner and skips it, so the
  // owner can only re-win through an IDLE cycle.
  always_comb begin
    base  = (state_q == BUSY) ? gid_q : last_winner_q;
    span  = (state_q == BUSY) ? N - 1 : N;
    found = 1'b0;
    sel   = '0;
    idx   = '0;
    for (int k = 1; k <= N; k++) begin
      idx = IW'((int'(base) + k) % N);
      if (!found && k <= span && in_valid[idx]) begin
        found = 1'b1;
        sel   = idx;
      end
    end
  end

  always_comb begin
    state_d       = state_q;
    grant_d       = grant_q;
    gid_d         = gid_q;
    last_winner_d = last_winner_q;
    case (state_q)
      IDLE: begin
        if (found) begin
          state_d = BUSY;
          grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
          gid_d   = sel;
        end
      end
      BUSY: begin
        if (out_valid && out_ready && out_last) begin
          last_winner_d = gid_q;
          if (found) begin
            grant_d = {{(N-1){1'b0}}, 1'b1} << sel;
            gid_d   = sel;
          end else begin
            state_d = IDLE;
            grant_d = '0;
            gid_d   = '0;
          end
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        gid_d   = '0;
      end
    endcase
  end

endmodule

// File: tb/tb_rr_packet_mux.sv
// Directed bench for rr_packet_mux: queued per-port sources, logged grant/beat traces vs hand tables.
module tb_rr_packet_mux;
  localparam int N  = 3;
  localparam int DW = 64;
  localparam int IW = 2;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    in_valid = '0;
  logic [N*DW-1:0] in_data = '0;
  logic [N-1:0]    in_last = '0;
  logic [N-1:0]    in_ready;
  logic            out_valid;
  logic [DW-1:0]   out_data;
  logic            out_last;
  logic [IW-1:0]   out_id;
  logic            out_ready = 1'b1;
  logic [N-1:0]    grant;

  rr_packet_mux #(.N(N), .DW(DW)) dut (
    .clk(clk), .rst(rst), .in_valid(in_valid), .in_data(in_data), .in_last(in_last),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data), .out_last(out_last),
    .out_id(out_id), .out_ready(out_ready), .grant(grant)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  logic [DW:0]    srcq [N][$];
  logic [N-1:0]   g_log [$];
  logic [DW-1:0]  d_log [$];
  logic           l_log [$];
  logic [IW-1:0]  id_log [$];

  logic [N-1:0]   s_grant, s_ir;
  logic           s_ov, s_ol;
  logic [DW-1:0]  s_od;
  logic [IW-1:0]  s_id;

  function automatic logic [DW-1:0] mk(int p, int k, int b);
    return {8'(p), 8'(k), 8'(b), 40'hA5_5A_C3_3C_00};
  endfunction

  task automatic push_pkt(int p, int k, int nb);
    for (int b = 0; b < nb; b++) srcq[p].push_back({(b == nb - 1) ? 1'b1 : 1'b0, mk(p, k, b)});
  endtask

  task automatic drive();
    for (int i = 0; i < N; i++) begin
      if (srcq[i].size() > 0) begin
        in_valid[i] = 1'b1;
        {in_last[i], in_data[i*DW +: DW]} = srcq[i][0];
      end else begin
        in_valid[i] = 1'b0;
        in_last[i]  = 1'b0;
        in_data[i*DW +: DW] = '0;
      end
    end
  endtask

  task automatic tick();
    logic [N-1:0] hs;
    @(negedge clk);
    s_grant = grant; s_ov = out_valid; s_od = out_data; s_ol = out_last; s_id = out_id; s_ir = in_ready;
    g_log.push_back(grant);
    if (out_valid && out_ready) begin
      d_log.push_back(out_data); l_log.push_back(out_last); id_log.push_back(out_id);
    end
    hs = in_valid & in_ready;
    @(posedge clk); #1;
    for (int i = 0; i < N; i++) if (hs[i]) void'(srcq[i].pop_front());
    drive();
  endtask

  task automatic clear_logs();
    g_log.delete(); d_log.delete(); l_log.delete(); id_log.delete();
  endtask

  task automatic do_reset();
    rst = 1'b1; out_ready = 1'b1;
    for (int i = 0; i < N; i++) srcq[i].delete();
    drive();
    tick();
    rst = 1'b0;
    clear_logs();
  endtask

  task automatic test_reset();
    do_reset();
    tick();
    n_cmp++; if (s_grant !== 3'b000) begin n_bad++; $display("FAIL reset_grant got %b want 000", s_grant); end
    n_cmp++; if (s_ov !== 1'b0 || s_ol !== 1'b0) begin n_bad++; $display("FAIL reset_out got v=%b l=%b want 0 0", s_ov, s_ol); end
    n_cmp++; if (s_ir !== 3'b000 || s_id !== 2'd0 || s_od !== '0) begin n_bad++; $display("FAIL reset_misc got ir=%b id=%0d d=%h want 000 0 0", s_ir, s_id, s_od); end
  endtask

  task automatic test_single_packet();
    logic [N-1:0] eg [5] = '{3'b000, 3'b010, 3'b010, 3'b010, 3'b000};
    do_reset();
    push_pkt(1, 0, 3); drive();
    for (int c = 0; c < 5; c++) tick();
    for (int c = 0; c < 5; c++) begin
      n_cmp++; if (g_log[c] !== eg[c]) begin n_bad++; $display("FAIL single_grant[%0d] got %b want %b", c, g_log[c], eg[c]); end
    end
    n_cmp++; if (d_log.size() != 3) begin n_bad++; $display("FAIL single_count got %0d want 3", d_log.size()); end
    for (int b = 0; b < 3 && b < d_log.size(); b++) begin
      n_cmp++;
      if (d_log[b] !== mk(1, 0, b) || l_log[b] !== (b == 2) || id_log[b] !== 2'd1) begin
        n_bad++; $display("FAIL single_beat[%0d] got d=%h l=%b id=%0d want d=%h l=%b id=1", b, d_log[b], l_log[b], id_log[b], mk(1, 0, b), b == 2);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] eg [12] = '{3'b000, 3'b001, 3'b001, 3'b010, 3'b010, 3'b100, 3'b100,
                              3'b001, 3'b001, 3'b010, 3'b010, 3'b000};
    int ep [5] = '{0, 1, 2, 0, 1};
    int ek [5] = '{0, 0, 0, 1, 1};
    do_reset();
    push_pkt(0, 0, 2); push_pkt(0, 1, 2);
    push_pkt(1, 0, 2); push_pkt(1, 1, 2);
    push_pkt(2, 0, 2);
    drive();
    for (int c = 0; c < 12; c++) tick();
    for (int c = 0; c < 12; c++) begin
      n_cmp++; if (g_log[c] !== eg[c]) begin n_bad++; $display("FAIL b2b_grant[%0d] got %b want %b", c, g_log[c], eg[c]); end
    end
    n_cmp++; if (d_log.size() != 10) begin n_bad++; $display("FAIL b2b_count got %0d want 10", d_log.size()); end
    for (int j = 0; j < 10 && j < d_log.size(); j++) begin
      n_cmp++;
      if (d_log[j] !== mk(ep[j/2], ek[j/2], j % 2) || id_log[j] !== IW'(ep[j/2]) || l_log[j] !== (j % 2 == 1)) begin
        n_bad++; $display("FAIL b2b_beat[%0d] got d=%h id=%0d want d=%h id=%0d", j, d_log[j], id_log[j], mk(ep[j/2], ek[j/2], j % 2), ep[j/2]);
      end
    end
  endtask

  task automatic test_stall();
    do_reset();
    push_pkt(0, 0, 4); drive();
    tick(); tick();
    out_ready = 1'b0;
    for (int c = 0; c < 2; c++) begin
      tick();
      n_cmp++;
      if (s_grant !== 3'b001 || s_ov !== 1'b1 || s_od !== mk(0, 0, 1) || s_ir !== 3'b000) begin
        n_bad++; $display("FAIL stall[%0d] got g=%b v=%b d=%h ir=%b want 001 1 %h 000", c, s_grant, s_ov, s_od, s_ir, mk(0, 0, 1));
      end
    end
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) tick();
    n_cmp++; if (d_log.size() != 4) begin n_bad++; $display("FAIL stall_count got %0d want 4", d_log.size()); end
    for (int b = 0; b < 4 && b < d_log.size(); b++) begin
      n_cmp++; if (d_log[b] !== mk(0, 0, b)) begin n_bad++; $display("FAIL stall_beat[%0d] got %h want %h", b, d_log[b], mk(0, 0, b)); end
    end
  endtask

  task automatic test_lock();
    logic [N-1:0] eg [11] = '{3'b000, 3'b100, 3'b100, 3'b100, 3'b100, 3'b001, 3'b001,
                              3'b010, 3'b010, 3'b000, 3'b000};
    do_reset();
    push_pkt(2, 0, 4); drive();
    tick();
    push_pkt(0, 0, 2); push_pkt(1, 0, 2); drive();
    for (int c = 0; c < 10; c++) tick();
    for (int c = 0; c < 11; c++) begin
      n_cmp++; if (g_log[c] !== eg[c]) begin n_bad++; $display("FAIL lock_grant[%0d] got %b want %b", c, g_log[c], eg[c]); end
    end
  endtask

  task automatic test_one_bubble();
    logic [N-1:0] eg [7] = '{3'b000, 3'b001, 3'b001, 3'b000, 3'b001, 3'b001, 3'b000};
    do_reset();
    push_pkt(0, 0, 2); push_pkt(0, 1, 2); drive();
    for (int c = 0; c < 7; c++) tick();
    for (int c = 0; c < 7; c++) begin
      n_cmp++; if (g_log[c] !== eg[c]) begin n_bad++; $display("FAIL bubble_grant[%0d] got %b want %b", c, g_log[c], eg[c]); end
    end
    n_cmp++; if (d_log.size() != 4) begin n_bad++; $display("FAIL bubble_count got %0d want 4", d_log.size()); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    push_pkt(1, 0, 3); drive();
    tick(); tick();
    rst = 1'b1;
    tick();
    n_cmp++; if (s_grant !== 3'b010 || s_od !== mk(1, 0, 1)) begin n_bad++; $display("FAIL mrst_pre got g=%b d=%h want 010 %h", s_grant, s_od, mk(1, 0, 1)); end
    for (int i = 0; i < N; i++) srcq[i].delete();
    push_pkt(0, 0, 2); push_pkt(1, 1, 2); drive();
    tick();
    n_cmp++; if (s_grant !== 3'b000 || s_ov !== 1'b0 || s_ir !== 3'b000) begin n_bad++; $display("FAIL mrst_idle got g=%b v=%b ir=%b want 000 0 000", s_grant, s_ov, s_ir); end
    rst = 1'b0;
    tick();
    n_cmp++; if (s_grant !== 3'b000) begin n_bad++; $display("FAIL mrst_arb got %b want 000", s_grant); end
    tick();
    n_cmp++; if (s_grant !== 3'b001 || s_id !== 2'd0 || s_od !== mk(0, 0, 0)) begin n_bad++; $display("FAIL mrst_win got g=%b id=%0d d=%h want 001 0 %h", s_grant, s_id, s_od, mk(0, 0, 0)); end
  endtask

  initial begin
    test_reset();
    test_single_packet();
    test_back_to_back();
    test_stall();
    test_lock();
    test_one_bubble();
    test_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
